// File: rtl/bbox_pkg.sv
// Shared types and constants for the binary mask bounding-box detector.
// Optional smoothing of published boxes is enabled by defining BBOX_SMOOTH_EN.
package bbox_pkg;

    localparam int COORD_W = 12;
    localparam int CNT_W   = 20;
    localparam int RUN_W   = 4;

    // Default frame geometry; the reset box spans the whole frame.
    localparam int DEF_IW = 1024;
    localparam int DEF_IH = 768;
    localparam logic [COORD_W-1:0] BOX_ORIGIN = '0;

    typedef enum logic [1:0] {
        WAIT_VS,
        ACCUM,
        PUBLISH
    } state_t;

    // (3*prev + new + 2) >> 2; 14 bits hold the worst case 4*4095+2.
    function automatic logic [COORD_W-1:0] smooth(input logic [COORD_W-1:0] prev,
                                                   input logic [COORD_W-1:0] nxt);
        logic [COORD_W+1:0] sum;
        sum = {2'b00, prev} + {1'b0, prev, 1'b0} + {2'b00, nxt} + 14'd2;
        return sum[COORD_W+1:2];
    endfunction

endpackage

// File: rtl/bbox_run_filter.sv
// Horizontal run-length filter: only runs of at least RUN_MIN consecutive
// foreground pixels on one line contribute to the bounding box and count.
module bbox_run_filter
    import bbox_pkg::*;
#(
    parameter int RUN_MIN = 4
) (
    input  logic               pixelclk,
    input  logic               reset,
    input  logic               i_binary,
    input  logic               i_de,
    input  logic [COORD_W-1:0] hcount,
    output logic               accept,
    output logic [COORD_W-1:0] left_x,
    output logic [COORD_W-1:0] right_x,
    output logic [RUN_W-1:0]   add_cnt
);

    localparam logic [RUN_W-1:0]   RUN_SAT = RUN_W'(RUN_MIN);
    localparam logic [COORD_W-1:0] RUN_OFS = COORD_W'(RUN_MIN - 1);

    logic             hit;
    logic [RUN_W-1:0] run;

    assign hit = i_de & i_binary;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge pixelclk) begin
        if (reset || !hit) begin
            run <= '0;
        end else if (run != RUN_SAT) begin
            run <= run + RUN_W'(1);
        end
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        accept  = 1'b0;
        left_x  = hcount;
        right_x = hcount;
        add_cnt = '0;
        if (hit) begin
            if (run == RUN_SAT) begin
                accept  = 1'b1;
                add_cnt = RUN_W'(1);
            end else if (run == RUN_SAT - RUN_W'(1)) begin
                // Run just qualified: credit the pixels that were held back.
                accept  = 1'b1;
                add_cnt = RUN_SAT;
                left_x  = hcount - RUN_OFS;
            end
        end
    end

endmodule

// File: rtl/binary_bbox_detect.sv
// Per-frame bounding box and pixel count of a run-filtered binary mask.
// Define BBOX_SMOOTH_EN to average each published box with the previous one.
module binary_bbox_detect
    import bbox_pkg::*;
#(
    parameter int IW         = DEF_IW,
    parameter int IH         = DEF_IH,
    parameter int MIN_PIXELS = 64,
    parameter int RUN_MIN    = 4,
    parameter bit VS_POL     = 1'b1
) (
    input  logic               pixelclk,
    input  logic               reset,
    input  logic               i_binary,
    input  logic               i_de,
    input  logic               i_vsync,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    output logic [COORD_W-1:0] hcount_l,
    output logic [COORD_W-1:0] hcount_r,
    output logic [COORD_W-1:0] vcount_l,
    output logic [COORD_W-1:0] vcount_r,
    output logic               o_found,
    output logic               o_box_valid,
    output logic [CNT_W-1:0]   o_pix_cnt
);

    localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(IW - 1);
    localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(IH - 1);
    localparam logic [CNT_W-1:0]   MIN_CNT = CNT_W'(MIN_PIXELS);

    state_t             state, state_nxt;
    logic               vs_d, vs_edge;
    logic               acc_clr, acc_en, publish;
    logic               accept;
    logic [COORD_W-1:0] left_x, right_x;
    logic [RUN_W-1:0]   add_cnt;
    logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     cnt_sum;

    bbox_run_filter #(.RUN_MIN(RUN_MIN)) u_run_filter (
        .pixelclk (pixelclk),
        .reset    (reset),
        .i_binary (i_binary),
        .i_de     (i_de),
        .hcount   (hcount),
        .accept   (accept),
        .left_x   (left_x),
        .right_x  (right_x),
        .add_cnt  (add_cnt)
    );

    assign vs_edge = (vs_d != VS_POL) && (i_vsync == VS_POL);

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            state <= WAIT_VS;
            vs_d  <= VS_POL;
        end else begin
            state <= state_nxt;
            vs_d  <= i_vsync;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_VS: if (vs_edge) state_nxt = ACCUM;
            ACCUM:   if (vs_edge) state_nxt = PUBLISH;
            PUBLISH: state_nxt = ACCUM;
            default: state_nxt = WAIT_VS;
        endcase
    end

    always_comb begin
        acc_clr = (state == PUBLISH) || (state == WAIT_VS && vs_edge);
        acc_en  = (state == ACCUM);
        publish = (state == PUBLISH);
    end

    assign cnt_sum = {1'b0, count} + (CNT_W + 1)'(add_cnt);

    always_ff @(posedge pixelclk) begin
        if (reset || acc_clr) begin
            min_x <= X_MAX;
            max_x <= BOX_ORIGIN;
            min_y <= Y_MAX;
            max_y <= BOX_ORIGIN;
            count <= '0;
        end else if (acc_en && accept) begin
            if (left_x < min_x)  min_x <= left_x;
            if (right_x > max_x) max_x <= right_x;
            if (vcount < min_y)  min_y <= vcount;
            if (vcount > max_y)  max_y <= vcount;
            count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            hcount_l    <= BOX_ORIGIN;
            hcount_r    <= X_MAX;
            vcount_l    <= BOX_ORIGIN;
            vcount_r    <= Y_MAX;
            o_found     <= 1'b0;
            o_box_valid <= 1'b0;
            o_pix_cnt   <= '0;
        end else begin
            o_box_valid <= publish;
            if (publish) begin
                o_pix_cnt <= count;
                if (count >= MIN_CNT) begin
                    o_found <= 1'b1;
`ifdef BBOX_SMOOTH_EN
                    if (o_found) begin
                        hcount_l <= smooth(hcount_l, min_x);
                        hcount_r <= smooth(hcount_r, max_x);
                        vcount_l <= smooth(vcount_l, min_y);
                        vcount_r <= smooth(vcount_r, max_y);
                    end else begin
                        hcount_l <= min_x;
                        hcount_r <= max_x;
                        vcount_l <= min_y;
                        vcount_r <= max_y;
                    end
`else
                    hcount_l <= min_x;
                    hcount_r <= max_x;
                    vcount_l <= min_y;
                    vcount_r <= max_y;
`endif
                end else begin
                    o_found  <= 1'b0;
                    hcount_l <= BOX_ORIGIN;
                    hcount_r <= X_MAX;
                    vcount_l <= BOX_ORIGIN;
                    vcount_r <= Y_MAX;
                end
            end
        end
    end

endmodule

// File: tb/tb_binary_bbox_detect.sv
// Directed bench for binary_bbox_detect; expected boxes are hand-computed.
// Frames are compacted: only the lines/columns of interest are driven.
module tb_binary_bbox_detect;

    logic        pixelclk = 1'b0;
    logic        reset = 1'b1;
    logic        i_binary = 1'b0;
    logic        i_de = 1'b0;
    logic        i_vsync = 1'b0;
    logic [11:0] hcount = '0;
    logic [11:0] vcount = '0;
    logic [11:0] hcount_l, hcount_r, vcount_l, vcount_r;
    logic        o_found, o_box_valid;
    logic [19:0] o_pix_cnt;

    int checks = 0;
    int failures = 0;

    binary_bbox_detect dut (
        .pixelclk    (pixelclk),
        .reset       (reset),
        .i_binary    (i_binary),
        .i_de        (i_de),
        .i_vsync     (i_vsync),
        .hcount      (hcount),
        .vcount      (vcount),
        .hcount_l    (hcount_l),
        .hcount_r    (hcount_r),
        .vcount_l    (vcount_l),
        .vcount_r    (vcount_r),
        .o_found     (o_found),
        .o_box_valid (o_box_valid),
        .o_pix_cnt   (o_pix_cnt)
    );

    always #5 pixelclk = ~pixelclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input bit de, input bit bin);
        @(negedge pixelclk);
        hcount   = 12'(x);
        vcount   = 12'(y);
        i_de     = de;
        i_binary = bin;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(0, 0, 1'b0, 1'b0);
    endtask

    task automatic rect_rows(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0 - 2; x <= x1 + 2; x++) pix(x, y, 1'b1, (x >= x0) && (x <= x1));
            pix(0, y, 1'b0, 1'b0);
            pix(0, y, 1'b0, 1'b0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_l"},     32'(hcount_l), 0);
        check({tag, "_r"},     32'(hcount_r), 1023);
        check({tag, "_t"},     32'(vcount_l), 0);
        check({tag, "_b"},     32'(vcount_r), 767);
        check({tag, "_found"}, 32'(o_found), 0);
        check({tag, "_valid"}, 32'(o_box_valid), 0);
        check({tag, "_cnt"},   32'(o_pix_cnt), 0);
    endtask

    // Raise vsync (optionally with a qualified pixel in the same cycle) and
    // check the box_valid timing and published values.
    task automatic vsync_frame(input string tag, input bit pub,
                               input int el, input int er, input int et, input int eb,
                               input bit ef, input int ec,
                               input bit px, input int px_x, input int px_y);
        logic v0, v1, v2;
        logic [11:0] l, r, t, b;
        logic f;
        logic [19:0] c;
        @(negedge pixelclk);
        i_vsync  = 1'b1;
        i_de     = px;
        i_binary = px;
        hcount   = 12'(px_x);
        vcount   = 12'(px_y);
        @(negedge pixelclk);
        i_de = 1'b0;
        i_binary = 1'b0;
        v0 = o_box_valid;
        @(negedge pixelclk);
        v1 = o_box_valid;
        l = hcount_l; r = hcount_r; t = vcount_l; b = vcount_r; f = o_found; c = o_pix_cnt;
        @(negedge pixelclk);
        v2 = o_box_valid;
        i_vsync = 1'b0;
        idle(2);
        if (pub) begin
            check({tag, "_v0"},    32'(v0), 0);
            check({tag, "_v1"},    32'(v1), 1);
            check({tag, "_v2"},    32'(v2), 0);
            check({tag, "_l"},     32'(l), 32'(el));
            check({tag, "_r"},     32'(r), 32'(er));
            check({tag, "_t"},     32'(t), 32'(et));
            check({tag, "_b"},     32'(b), 32'(eb));
            check({tag, "_found"}, 32'(f), 32'(ef));
            check({tag, "_cnt"},   32'(c), 32'(ec));
        end else begin
            check({tag, "_nopub"}, 32'({v0, v1, v2}), 0);
        end
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        @(negedge pixelclk);
        check_reset_state("rst");

        // First edge after reset only arms accumulation; then two blank frames.
        vsync_frame("vs_first", 1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0);
        idle(10);
        vsync_frame("blank1", 1'b1, 0, 1023, 0, 767, 1'b0, 0, 1'b0, 0, 0);
        idle(10);
        vsync_frame("blank2", 1'b1, 0, 1023, 0, 767, 1'b0, 0, 1'b0, 0, 0);

        rect_rows(100, 199, 50, 149);
        vsync_frame("rect", 1'b1, 100, 199, 50, 149, 1'b1, 10000, 1'b0, 0, 0);

        // Short runs are rejected, including a run split across a line end.
        for (int x = 10; x <= 12; x++) pix(x, 10, 1'b1, 1'b1);
        pix(13, 10, 1'b1, 1'b0);
        for (int x = 500; x <= 503; x++) pix(x, 10, 1'b1, 1'b1);
        pix(504, 10, 1'b1, 1'b0);
        for (int x = 1021; x <= 1023; x++) pix(x, 20, 1'b1, 1'b1);
        pix(0, 20, 1'b0, 1'b0);
        for (int x = 0; x <= 2; x++) pix(x, 21, 1'b1, 1'b1);
        idle(2);
        vsync_frame("runs", 1'b1, 0, 1023, 0, 767, 1'b0, 4, 1'b0, 0, 0);

        // Last run of the frame completes on the vsync edge cycle at (1023,767).
        rect_rows(1000, 1022, 760, 766);
        for (int x = 1020; x <= 1022; x++) pix(x, 767, 1'b1, 1'b1);
        vsync_frame("edge_px", 1'b1, 1000, 1023, 760, 767, 1'b1, 165, 1'b1, 1023, 767);

        // Reset mid-frame: partial frame is discarded, no publish on next edge.
        rect_rows(100, 199, 50, 99);
        @(negedge pixelclk);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge pixelclk);
        check_reset_state("midrst");
        rect_rows(100, 199, 100, 149);
        vsync_frame("after_rst", 1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0);
        rect_rows(100, 199, 50, 149);
        vsync_frame("rect2", 1'b1, 100, 199, 50, 149, 1'b1, 10000, 1'b0, 0, 0);

        rect_rows(100, 199, 50, 149);
        vsync_frame("frame_a", 1'b1, 100, 199, 50, 149, 1'b1, 10000, 1'b0, 0, 0);
        rect_rows(200, 299, 50, 149);
`ifdef BBOX_SMOOTH_EN
        vsync_frame("frame_b", 1'b1, 125, 224, 50, 149, 1'b1, 10000, 1'b0, 0, 0);
`else
        vsync_frame("frame_b", 1'b1, 200, 299, 50, 149, 1'b1, 10000, 1'b0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/binary_bbox_detect.md
Name: binary_bbox_detect

Overview:
- Downstream of the HV counter/window stage. Consumes its windowed binary mask together with its hcount/vcount and sync signals.
- Per frame, finds the bounding box of foreground pixels, after a horizontal run-length noise filter, and counts those pixels.
- At each frame boundary it publishes hcount_l/hcount_r/vcount_l/vcount_r. These feed back into the counter stage's window inputs for the next frame.

Parameters:
- IW, 1024, active pixels per line; hcount range 0..IW-1
- IH, 768, active lines per frame; vcount range 0..IH-1
- MIN_PIXELS, 64, minimum accepted pixel count for the frame to report "found"
- RUN_MIN, 4, consecutive binary=1 pixels on one line needed before pixels are accepted; range 1..15
- VS_POL, 1, active level of i_vsync

Ports:
- pixelclk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- i_binary  in  1  binary mask pixel, qualified by i_de
- i_de  in  1  active video
- i_vsync  in  1  vertical sync
- hcount  in  12  pixel column of the current pixel
- vcount  in  12  line of the current pixel
- hcount_l  out  12  box left column
- hcount_r  out  12  box right column
- vcount_l  out  12  box top line
- vcount_r  out  12  box bottom line
- o_found  out  1  level; last published frame met MIN_PIXELS
- o_box_valid  out  1  one-cycle strobe when box outputs update
- o_pix_cnt  out  20  accepted pixel count of the last published frame; saturating

Behaviour:
- Clock and reset: one clock, pixelclk. reset is synchronous and active-high.
- Reset values: hcount_l=0, hcount_r=IW-1, vcount_l=0, vcount_r=IH-1, o_found=0, o_box_valid=0, o_pix_cnt=0, state=WAIT_VS.
- Frame boundary: the active edge of i_vsync is detected against a registered copy (vs_d!=VS_POL and i_vsync==VS_POL).
- States:
  - WAIT_VS: ignores all pixels, discarding the partial frame after reset. On a vsync edge -> ACCUM with accumulators cleared.
  - ACCUM: accumulates. On a vsync edge -> PUBLISH.
  - PUBLISH: one cycle. Loads the outputs, pulses o_box_valid in the following cycle, clears the accumulators -> ACCUM.
- Latency: vsync edge sampled at cycle N; PUBLISH in N+1; outputs and o_box_valid visible in N+2.
- Run filter:
  - run counter (4 bits) increments on i_de&i_binary, saturating at RUN_MIN.
  - Cleared on i_binary=0 or i_de=0, so a run never spans lines.
  - When the run first reaches RUN_MIN, the pixel at hcount-(RUN_MIN-1) is taken as the left candidate and RUN_MIN pixels are added to the count.
  - Each later pixel in the same run adds 1 and updates the right candidate to hcount.
- Accumulators:
  - min_x/max_x/min_y/max_y start at min=IW-1/IH-1 and max=0; each is updated with compare-and-replace.
  - 20-bit count saturates at 2^20-1.
- Publish rule:
  - count>=MIN_PIXELS: outputs get min_x, max_x, min_y, max_y; o_found=1.
  - Otherwise: outputs revert to the full-frame defaults; o_found=0.
  - o_pix_cnt always gets count.
- Simultaneous events: a pixel qualified in the same cycle as the vsync edge is still accumulated into the closing frame. A vsync edge during PUBLISH is ignored.
- reset mid-frame returns to WAIT_VS; no publish occurs.
- Box outputs hold between publishes.

Optional Feature:
- Macro: BBOX_SMOOTH_EN.
- Defined:
  - Each published coordinate = (3*prev + new + 2)>>2, computed with a 14-bit intermediate.
  - When the previous publish had o_found=0, new values load directly with no averaging.
  - Not-found frames still revert to the defaults.
- Undefined: direct load as above. No extra registers.

Decomposition:
- Package bbox_pkg holds: the state enum (WAIT_VS, ACCUM, PUBLISH), coordinate width (12), count width (20), and reset box constants.
- One natural sub-module: bbox_run_filter.
  - Contains the run counter and left/right candidate generation.
  - Outputs: accept strobe, left x, right x, add-count.
- The top module holds the FSM, accumulators and the optional smoother.

Test Plan:
- Reset, then 2 blank frames -> o_box_valid pulses at N+2 of each vsync edge; box 0/1023/0/767; o_found=0; o_pix_cnt=0.
- Solid rectangle x 100..199, y 50..149 -> box 100/199/50/149; o_found=1; o_pix_cnt=10000.
- Isolated 3-pixel runs plus one 4-pixel run at x 500..503, y 10 -> pix_cnt=4; o_found=0 (MIN_PIXELS=64); box at defaults.
- reset asserted mid-frame, then a full frame with the rectangle -> the first vsync after reset gives no publish; the next publishes 100/199/50/149.
- Pixel at (1023,767) with i_binary=1 in the same cycle as the vsync edge -> included; box right/bottom = 1023/767.
- With BBOX_SMOOTH_EN: frame A box 100/199/50/149, then frame B 200/299/50/149 -> second publish hcount_l=125, hcount_r=224.
